// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-issue RV32I core.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned IMEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       is_alu_reg,
    input  logic       is_alu_imm,
    input  logic       is_branch,
    input  logic       is_jal,
    input  logic       is_jalr,
    input  logic       is_lui,
    input  logic       is_auipc,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       is_system,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic [2:0] state,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       retire,
    output logic       halted,
    output logic       trap
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        trap_q;
    logic        trap_set;
    logic        timeout;
    logic [15:0] wait_cnt;
    logic [9:0]  flags;

    assign flags = {is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr,
                    is_lui, is_auipc, is_load, is_store, is_system};

    // Counts imem wait cycles of the current fetch; the compare is constant-false when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_q != S_FETCH) begin
            wait_cnt <= '0;
        end else if (!imem_ready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout = (IMEM_WAIT_MAX != 0) && (wait_cnt == 16'(IMEM_WAIT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (trap_set) begin
                trap_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        retire   = 1'b0;
        trap_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d  = S_HALT;
                    trap_set = 1'b1;
                end
            end
            S_DECODE: begin
                if (!$onehot(flags)) begin
                    state_d  = S_HALT;
                    trap_set = 1'b1;
                end else if (is_system) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    // A store has nothing to write back, so it retires here.
                    if (is_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_we  = 1'b1;
                retire = 1'b1;
                rf_we  = is_alu_reg | is_alu_imm | is_load | is_jal |
                         is_jalr | is_lui | is_auipc;
                if (is_branch && branch_taken) begin
                    pc_sel = 2'd1;
                end else if (is_jal) begin
                    pc_sel = 2'd2;
                end else if (is_jalr) begin
                    pc_sel = 2'd3;
                end
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state  = state_q;
    assign halted = (state_q == S_HALT);
    assign trap   = trap_q;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            end
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, corner sequences and
// randomized instructions checked against a latency/enable model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [9:0] fl  = '0;
    logic       branch_taken  = 1'b0;
    logic       imem_ready    = 1'b0;
    logic       dmem_ready    = 1'b0;
    logic       imem_ready_to = 1'b0;

    logic [2:0] state, to_state;
    logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, retire, halted, trap;
    logic [1:0] pc_sel, to_pc_sel;
    logic       to_imem_req, to_ir_we, to_dmem_req, to_dmem_we, to_rf_we, to_pc_we;
    logic       to_retire, to_halted, to_trap;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt, to_cycle_cnt, to_instret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // flag bit positions: 9 alu_reg, 8 alu_imm, 7 branch, 6 jal, 5 jalr,
    // 4 lui, 3 auipc, 2 load, 1 store, 0 system
    typedef struct {
        logic [9:0] fl;
        logic       tk;
        int         iw;
        int         dw;
        logic       keep;
        int         lat;
        int         rf;
        int         sel;
        int         dwe;
        logic       hlt;
        logic       trp;
    } vec_t;

    vec_t tbl[14];
    int   exp_st[6]    = '{0, 1, 2, 3, 5, 1};
    int   exp_to_st[6] = '{0, 1, 1, 1, 1, 6};

    int r_lat, r_hcyc, r_rf, r_pc, r_ir, r_sel, r_dwe, r_mis, r_done;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_WIDTH(32), .IMEM_WAIT_MAX(0)) u_dut (
        .clk(clk), .rst(rst), .run(run),
        .is_alu_reg(fl[9]), .is_alu_imm(fl[8]), .is_branch(fl[7]), .is_jal(fl[6]),
        .is_jalr(fl[5]), .is_lui(fl[4]), .is_auipc(fl[3]), .is_load(fl[2]),
        .is_store(fl[1]), .is_system(fl[0]),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .state(state), .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .retire(retire), .halted(halted), .trap(trap)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // Second instance with a fetch timeout and an instruction memory that never answers.
    multicycle_ctrl #(.CNT_WIDTH(32), .IMEM_WAIT_MAX(3)) u_to (
        .clk(clk), .rst(rst), .run(run),
        .is_alu_reg(fl[9]), .is_alu_imm(fl[8]), .is_branch(fl[7]), .is_jal(fl[6]),
        .is_jalr(fl[5]), .is_lui(fl[4]), .is_auipc(fl[3]), .is_load(fl[2]),
        .is_store(fl[1]), .is_system(fl[0]),
        .branch_taken(branch_taken), .imem_ready(imem_ready_to), .dmem_ready(dmem_ready),
        .state(to_state), .imem_req(to_imem_req), .ir_we(to_ir_we), .dmem_req(to_dmem_req),
        .dmem_we(to_dmem_we), .rf_we(to_rf_we), .pc_we(to_pc_we), .pc_sel(to_pc_sel),
        .retire(to_retire), .halted(to_halted), .trap(to_trap)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(to_cycle_cnt), .instret_cnt(to_instret_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        fl  = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #2;
        rst = 1'b0;
        tick();
    endtask

    // Reference: cycles counted from the first cycle of the instruction
    // (the IDLE cycle with run=1 when starting idle, else the first FETCH cycle).
    task automatic model(input logic [9:0] f, input logic tk, input int iw, input int dw,
                         input bit start_idle, output int lat, output int rf,
                         output int sel, output int dwe, output logic hlt, output logic trp);
        int n;
        n   = $countones(f);
        trp = (n != 1);
        hlt = trp || f[0];
        if (hlt) begin
            lat = (start_idle ? 1 : 0) + iw + 3;
        end else begin
            lat = 5 + iw - (start_idle ? 0 : 1);
            if (f[2]) lat += 1 + dw;
            if (f[1]) lat += dw;
        end
        rf  = (f[7] || f[1]) ? 0 : 1;
        sel = (f[7] && tk) ? 1 : f[6] ? 2 : f[5] ? 3 : 0;
        dwe = f[1] ? 1 : 0;
    endtask

    task automatic exec_instr(input logic [9:0] f, input logic tk, input int iw,
                              input int dw, input logic keep);
        int cyc, icnt, dcnt;
        fl = f;
        branch_taken = tk;
        run = 1'b1;
        cyc = 0; icnt = 0; dcnt = 0;
        r_lat = -1; r_hcyc = -1; r_rf = 0; r_pc = 0; r_ir = 0;
        r_sel = -1; r_dwe = 0; r_mis = 0; r_done = 0;
        while (r_done == 0 && cyc < 200) begin
            cyc++;
            if (cyc == 2) run = keep;
            imem_ready = imem_req && (icnt == iw);
            if (imem_req) icnt++;
            dmem_ready = dmem_req && (dcnt == dw);
            if (dmem_req) dcnt++;
            #1;
            r_rf += int'(rf_we);
            r_pc += int'(pc_we);
            r_ir += int'(ir_we);
            if (dmem_we) r_dwe = 1;
            if (pc_we != retire) r_mis = 1;
            if (retire) begin
                r_lat  = cyc;
                r_sel  = int'(pc_sel);
                r_done = 1;
            end
            if (state == 3'd6) begin
                r_hcyc = cyc;
                r_done = 1;
            end
            tick();
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (r_done == 0) chk("instr_bound_expired", 0, 1);
    endtask

    task automatic check_instr(input string tag, input logic [9:0] f, input logic tk,
                               input int iw, input int dw, input logic keep,
                               input int lat, input int rf, input int sel, input int dwe,
                               input logic hlt, input logic trp);
        int stay;
        exec_instr(f, tk, iw, dw, keep);
        if (hlt) begin
            chk({tag, "_halt_cycle"}, r_hcyc, lat);
            chk({tag, "_halted"}, int'(halted), 1);
            chk({tag, "_trap"}, int'(trap), int'(trp));
            chk({tag, "_no_retire"}, r_pc, 0);
            stay = 0;
            repeat (20) begin
                tick();
                if (state == 3'd6 && halted && trap == trp && !imem_req && !dmem_req && !pc_we)
                    stay++;
            end
            chk({tag, "_halt_stay"}, stay, 20);
            do_reset();
        end else begin
            chk({tag, "_latency"}, r_lat, lat);
            chk({tag, "_rf_we_count"}, r_rf, rf);
            chk({tag, "_pc_we_count"}, r_pc, 1);
            chk({tag, "_ir_we_count"}, r_ir, 1);
            chk({tag, "_pc_sel"}, r_sel, sel);
            chk({tag, "_dmem_we"}, r_dwe, dwe);
            chk({tag, "_pc_we_vs_retire"}, r_mis, 0);
            chk({tag, "_next_state"}, int'(state), keep ? 1 : 0);
        end
    endtask

    initial begin
        int r, a, b, k, iw, dw, lat, rf, sel, dwe;
        logic [9:0] f;
        logic tk, keep, hlt, trp;
        bit start_idle;

        //            fl            tk  iw dw keep lat rf sel dwe hlt trp
        tbl[0]  = '{10'b0100000000, 0, 0, 0, 0,  5, 1, 0, 0, 0, 0};
        tbl[1]  = '{10'b0000000100, 0, 2, 3, 0, 11, 1, 0, 0, 0, 0};
        tbl[2]  = '{10'b0010000000, 1, 0, 0, 0,  5, 0, 1, 0, 0, 0};
        tbl[3]  = '{10'b0010000000, 0, 1, 0, 0,  6, 0, 0, 0, 0, 0};
        tbl[4]  = '{10'b0000100000, 0, 0, 0, 0,  5, 1, 3, 0, 0, 0};
        tbl[5]  = '{10'b0001000000, 1, 0, 0, 0,  5, 1, 2, 0, 0, 0};
        tbl[6]  = '{10'b0000010000, 0, 0, 0, 0,  5, 1, 0, 0, 0, 0};
        tbl[7]  = '{10'b0000001000, 0, 3, 0, 0,  8, 1, 0, 0, 0, 0};
        tbl[8]  = '{10'b1000000000, 0, 0, 2, 0,  5, 1, 0, 0, 0, 0};
        tbl[9]  = '{10'b0000000010, 0, 0, 0, 0,  5, 0, 0, 1, 0, 0};
        tbl[10] = '{10'b0000000010, 0, 1, 2, 0,  8, 0, 0, 1, 0, 0};
        tbl[11] = '{10'b1000000100, 0, 0, 0, 0,  4, 0, 0, 0, 1, 1};
        tbl[12] = '{10'b0000000001, 0, 0, 0, 0,  4, 0, 0, 0, 1, 0};
        tbl[13] = '{10'b0000000000, 0, 1, 0, 0,  5, 0, 0, 0, 1, 1};

        #3;
        chk("reset_outputs", int'({state, imem_req, ir_we, dmem_req, dmem_we, rf_we,
                                   pc_we, pc_sel, retire, halted, trap}), 0);
        #9 rst = 1'b0;
        tick();

        // Zero-wait ALU-immediate walk, timeout instance alongside.
        run = 1'b1;
        fl = 10'b0100000000;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("seq_state_%0d", i), int'(state), exp_st[i]);
            chk($sformatf("seq_rf_we_%0d", i), int'(rf_we), (i == 4) ? 1 : 0);
            chk($sformatf("seq_retire_%0d", i), int'(retire), (i == 4) ? 1 : 0);
            chk($sformatf("to_state_%0d", i), int'(to_state), exp_to_st[i]);
            chk($sformatf("to_trap_%0d", i), int'(to_trap), (i == 5) ? 1 : 0);
            tick();
        end
        do_reset();

        for (int i = 0; i < 14; i++) begin
            check_instr($sformatf("vec%0d", i), tbl[i].fl, tbl[i].tk, tbl[i].iw, tbl[i].dw,
                        tbl[i].keep, tbl[i].lat, tbl[i].rf, tbl[i].sel, tbl[i].dwe,
                        tbl[i].hlt, tbl[i].trp);
        end

        // Asynchronous reset while a load waits in MEM.
        do_reset();
        fl = 10'b0000000100;
        run = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        k = 0;
        while (state != 3'd4 && k < 20) begin
            tick();
            k++;
        end
        chk("mem_reached", int'(state), 4);
        #1;
        chk("mem_dmem_req", int'(dmem_req), 1);
        rst = 1'b1;
        #1;
        chk("rst_dmem_req", int'(dmem_req), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_retire", int'(retire), 0);
        #1;
        rst = 1'b0;
        imem_ready = 1'b0;
        do_reset();

        start_idle = 1'b1;
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                f = 10'b0000000001;
            end else if (r == 1) begin
                a = int'($urandom_range(0, 9));
                b = (a + 1 + int'($urandom_range(0, 8))) % 10;
                f = (10'd1 << a) | (10'd1 << b);
            end else if (r == 2) begin
                f = '0;
            end else begin
                f = 10'd1 << $urandom_range(1, 9);
            end
            tk   = 1'($urandom_range(0, 1));
            iw   = int'($urandom_range(0, 3));
            dw   = int'($urandom_range(0, 3));
            keep = ($urandom_range(0, 3) != 0);
            model(f, tk, iw, dw, start_idle, lat, rf, sel, dwe, hlt, trp);
            check_instr($sformatf("rnd%0d", n), f, tk, iw, dw, keep, lat, rf, sel, dwe, hlt, trp);
            start_idle = hlt ? 1'b1 : !keep;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
